// File: rtl/result_out_sequencer.sv
// rtl/result_out_sequencer.sv - buffers core result words and drains them on the out/out_valid protocol
// Frame length is latched at frame start; a watchdog bounds the wait for done.
module result_out_sequencer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 8,
  parameter int LAT_MAX = 150,
  localparam int LEN_W  = $clog2(DEPTH + 1),
  localparam int WD_W   = $clog2(LAT_MAX + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              done_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_o,
  output logic              busy_o,
  output logic              timeout_o,
  output logic [2:0]        err_o
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [WD_W-1:0]  LAT_L   = WD_W'(LAT_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [DEPTH-1:0]    slot_vld_q, slot_vld_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                busy_q, busy_d;
  logic                timeout_q, timeout_d;
  logic [2:0]          err_q, err_d;
  logic [DATA_W-1:0]   buf_q [DEPTH];
  logic                wr_fire;
  logic [LEN_W-1:0]    len_clamp;
  logic [IDX_W-1:0]    wr_idx, rd_idx;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];

  always_comb begin
    len_clamp = len_i;
    if (len_i == '0) begin
      len_clamp = LEN_W'(1);
    end else if (len_i > DEPTH_L) begin
      len_clamp = DEPTH_L;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    wd_d        = wd_q;
    slot_vld_d  = slot_vld_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    timeout_d   = timeout_q;
    err_d       = err_q;
    wr_fire     = 1'b0;

    // Writes are accepted while the frame is open, including the cycle done arrives.
    if ((state_q == S_RECV || state_q == S_WAIT) && wr_en_i) begin
      if (wr_ptr_q == len_q) begin
        err_d[0] = 1'b1;
      end else begin
        wr_fire            = 1'b1;
        slot_vld_d[wr_idx] = 1'b1;
        wr_ptr_d           = wr_ptr_q + LEN_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          state_d    = S_RECV;
          len_d      = len_clamp;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          slot_vld_d = '0;
          timeout_d  = 1'b0;
          err_d      = '0;
        end
      end
      S_RECV: begin
        if (!in_valid_i) begin
          state_d = S_WAIT;
          wd_d    = '0;
        end
      end
      S_WAIT: begin
        if (done_i) begin
          state_d  = S_DRAIN;
          rd_ptr_d = '0;
        end else if (wd_q == LAT_L) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_DRAIN: begin
        // A new frame arriving mid-drain wins; ovl stays set so the collision is visible.
        if (in_valid_i) begin
          state_d    = S_RECV;
          len_d      = len_clamp;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          slot_vld_d = '0;
          timeout_d  = 1'b0;
          err_d      = 3'b100;
        end else begin
          out_valid_d = 1'b1;
          if (slot_vld_q[rd_idx]) begin
            out_d = buf_q[rd_idx];
          end else begin
            err_d[1] = 1'b1;
          end
          rd_ptr_d = rd_ptr_q + LEN_W'(1);
          if (rd_ptr_q + LEN_W'(1) == len_q) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wd_q        <= '0;
      slot_vld_q  <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wd_q        <= wd_d;
      slot_vld_q  <= slot_vld_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  // Slot contents need no reset: the slot-valid bits gate every read.
  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      buf_q[wr_idx] <= wr_data_i;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_o       = out_q;
  assign busy_o      = busy_q;
  assign timeout_o   = timeout_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_result_out_sequencer.sv
// tb/tb_result_out_sequencer.sv - randomized frame-level checks of result_out_sequencer
// Each frame's expected words and flags come from a per-frame write list and the clamped length.
module tb_result_out_sequencer;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int LAT_MAX = 150;
  localparam int LEN_W   = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [LEN_W-1:0]  len;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              out_valid;
  logic [DATA_W-1:0] out;
  logic              busy;
  logic              timeout;
  logic [2:0]        err;

  int errs   = 0;
  int checks = 0;

  result_out_sequencer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LAT_MAX(LAT_MAX)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .len_i       (len),
    .wr_en_i     (wr_en),
    .wr_data_i   (wr_data),
    .done_i      (done),
    .out_valid_o (out_valid),
    .out_o       (out),
    .busy_o      (busy),
    .timeout_o   (timeout),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic iv, input int ln, input logic we, input logic [31:0] wd, input logic dn);
    in_valid = iv;
    len      = LEN_W'(ln);
    wr_en    = we;
    wr_data  = wd;
    done     = dn;
    @(negedge clk);
    in_valid = 1'b0;
    wr_en    = 1'b0;
    done     = 1'b0;
  endtask

  // Cycle 0 opens the frame; cycles 1..n_iv+n_wait may carry writes; the last one carries done.
  task automatic frame(input int len_raw, input int n_iv, input int n_wait, input int n_wr,
                       input bit late, input bit cont, input int n_show, input bit tail,
                       input logic [2:0] err_pre);
    int L, E, left, ns;
    logic [31:0] w[$];
    logic [31:0] v, expw;
    logic we;
    logic [2:0] exp_err;
    L = (len_raw == 0) ? 1 : ((len_raw > DEPTH) ? DEPTH : len_raw);
    E = n_iv + n_wait;
    left = n_wr;
    for (int k = 0; k <= n_iv + n_wait; k++) begin
      if (k == 0 && cont) continue;
      we = 1'b0;
      if (k > 0 && left > 0) begin
        if (left >= E - (k - 1) || (!late && $urandom_range(1, 0) == 1)) we = 1'b1;
      end
      v = $urandom;
      if (we) begin
        w.push_back(v);
        left--;
      end
      cyc(k < n_iv, len_raw, we, v, k == n_iv + n_wait);
      if (k == 0) chk("busy_start", busy, 1);
    end
    chk("pre_valid", out_valid, 0);
    ns = (n_show < 0) ? L : n_show;
    for (int i = 0; i < ns; i++) begin
      @(negedge clk);
      expw = (i < w.size()) ? w[i] : 32'd0;
      chk($sformatf("valid%0d", i), out_valid, 1);
      chk($sformatf("word%0d", i), out, expw);
    end
    if (tail) begin
      @(negedge clk);
      exp_err = err_pre | {1'b0, (n_wr < L), (n_wr > L)};
      chk("end_valid", out_valid, 0);
      chk("end_out", out, 0);
      chk("end_busy", busy, 0);
      chk("end_timeout", timeout, 0);
      chk("end_err", err, exp_err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int k;
    bit saw;
    rst = 1'b1; in_valid = 1'b0; len = '0; wr_en = 1'b0; wr_data = '0; done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err", err, 0);

    frame(3, 72, 4, 3, 1, 0, -1, 1, 3'b000);
    frame(1, 4, 3, 1, 1, 0, -1, 1, 3'b000);
    frame(2, 3, 3, 3, 0, 0, -1, 1, 3'b000);
    frame(3, 3, 3, 2, 0, 0, -1, 1, 3'b000);
    frame(0, 2, 3, 1, 0, 0, -1, 1, 3'b000);
    frame(12, 3, 6, 8, 0, 0, -1, 1, 3'b000);
    frame(15, 2, 3, 3, 0, 0, -1, 1, 3'b000);

    // Watchdog expiry with no done
    for (int i = 0; i < 5; i++) cyc(1, 3, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    k = 0; saw = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
      if (out_valid) saw = 1;
    end
    chk("to_cycles", k, LAT_MAX + 1);
    chk("to_flag", timeout, 1);
    chk("to_no_valid", saw, 0);
    chk("to_busy", busy, 0);
    chk("to_err", err, 0);
    // done on the last allowed watchdog cycle still drains, and a new frame clears timeout
    frame(2, 2, LAT_MAX + 1, 2, 0, 0, -1, 1, 3'b000);

    // in_valid raised during the second drain cycle
    frame(3, 3, 3, 3, 0, 0, 1, 0, 3'b000);
    cyc(1, 2, 0, 0, 0);
    chk("ovl_valid", out_valid, 0);
    chk("ovl_out", out, 0);
    chk("ovl_err", err, 3'b100);
    chk("ovl_busy", busy, 1);
    frame(2, 3, 2, 2, 0, 1, -1, 1, 3'b100);

    // Back-to-back: new frame the cycle after the last word
    frame(2, 2, 2, 3, 0, 0, 2, 0, 3'b000);
    cyc(1, 2, 0, 0, 0);
    chk("b2b_valid", out_valid, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_err", err, 0);
    frame(2, 3, 2, 2, 0, 1, -1, 1, 3'b000);

    // Reset in the middle of a drain
    frame(3, 3, 3, 4, 0, 0, 2, 0, 3'b000);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_out", out, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);
    frame(3, 72, 4, 3, 1, 0, -1, 1, 3'b000);

    for (int f = 0; f < 24; f++) begin
      int lr, niv, nw, nwr;
      lr  = $urandom_range(15, 0);
      niv = $urandom_range(10, 1);
      nw  = $urandom_range(12, 1);
      nwr = $urandom_range(10, 0);
      if (nwr > niv + nw) nwr = niv + nw;
      frame(lr, niv, nw, nwr, $urandom_range(1, 0) == 1, 0, -1, 1, 3'b000);
      repeat ($urandom_range(3, 0)) cyc(0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
